// File: rtl/pio_input_debounce.sv
// pio_input_debounce: two-flop synchronizer plus per-bit debounce for PIO inputs; change capture built with PIO_INPUT_DEBOUNCE_CHANGE_CAPTURE_EN
module pio_input_debounce #(
   parameter int               WIDTH           = 8,
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] stable,
   output logic [WIDTH-1:0] change_mask,
   output logic             event_valid,
   input  logic             event_ack
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [WIDTH-1:0] r_s1, r_s2, r_stable, w_flip;
   // two-flop synchronizer for the asynchronous pins
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= RESET_VALUE;
         r_s2 <= RESET_VALUE;
      end else begin
         r_s1 <= raw_in;
         r_s2 <= r_s1;
      end
   end
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [CW-1:0] r_cnt;
      assign w_flip[i] = (r_s2[i] != r_stable[i]) && (r_cnt == LAST);
      // count consecutive cycles the synchronized level disagrees with the accepted one
      always_ff @(posedge clk) begin
         if (reset) r_cnt <= '0;
         else r_cnt <= (r_s2[i] == r_stable[i] || w_flip[i]) ? '0 : r_cnt + 1'b1;
      end
   end
   // accept a new level on every bit whose count has completed
   always_ff @(posedge clk) begin
      if (reset) r_stable <= RESET_VALUE;
      else r_stable <= r_stable ^ w_flip;
   end
   assign stable = r_stable;
`ifdef PIO_INPUT_DEBOUNCE_CHANGE_CAPTURE_EN
   logic [WIDTH-1:0] r_mask;
   // sticky record of transitions since the last ack; a flip landing with the ack is kept
   always_ff @(posedge clk) begin
      if (reset) r_mask <= '0;
      else r_mask <= event_ack ? w_flip : (r_mask | w_flip);
   end
   assign change_mask = r_mask;
   assign event_valid = |r_mask;
`else
   logic w_unused_ack;
   assign w_unused_ack = event_ack;
   assign change_mask  = '0;
   assign event_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_pio_input_debounce.sv
// tb_pio_input_debounce: directed and random checks of the debouncer against a sample-window model
module tb_pio_input_debounce;
   localparam int W = 8;
   localparam int D = 4;
   localparam logic [W-1:0] RV = 8'h00;
`ifdef PIO_INPUT_DEBOUNCE_CHANGE_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [W-1:0] raw_in = 8'hFF;
   logic event_ack = 1'b0;
   logic [W-1:0] stable, change_mask;
   logic event_valid;
   int checks = 0;
   int failures = 0;
   pio_input_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .RESET_VALUE(RV)) dut (
      .clk(clk), .reset(reset), .raw_in(raw_in), .stable(stable),
      .change_mask(change_mask), .event_valid(event_valid), .event_ack(event_ack)
   );
   always #5 clk = ~clk;
   // Model: a bit accepts a new level when the D raw samples taken two to D+1 edges ago all differ from it
   logic [W-1:0] hist [$];
   logic [W-1:0] m_stable = RV, m_mask = '0, m_flip;
   initial for (int p = 0; p <= D; p++) hist.push_back(RV);
   always @(posedge clk) begin
      if (reset) begin
         m_stable = RV;
         m_mask = '0;
         hist.push_back(RV);
      end else begin
         for (int b = 0; b < W; b++) begin
            m_flip[b] = 1'b1;
            for (int k = 0; k < D; k++) if (hist[k][b] == m_stable[b]) m_flip[b] = 1'b0;
         end
         m_stable = m_stable ^ m_flip;
         m_mask = event_ack ? m_flip : (m_mask | m_flip);
         hist.push_back(raw_in);
      end
      void'(hist.pop_front());
   end
   task automatic test_reset();
      reset = 1'b1; raw_in = 8'hFF; event_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (stable !== 8'h00 || change_mask !== 8'h00 || event_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got stable=%h mask=%h valid=%b want 00/00/0", c, stable, change_mask, event_valid);
         end
      end
      reset = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         @(negedge clk);
         checks++;
         if (stable !== (e == 6 ? 8'hFF : 8'h00)) begin
            failures++;
            $display("FAIL reset_release edge=%0d got stable=%h want %h", e, stable, (e == 6 ? 8'hFF : 8'h00));
         end
      end
      checks++;
      if (change_mask !== (CAP ? 8'hFF : 8'h00) || event_valid !== CAP) begin
         failures++;
         $display("FAIL reset_mask got mask=%h valid=%b want %h/%b", change_mask, event_valid, (CAP ? 8'hFF : 8'h00), CAP);
      end
   endtask
   task automatic test_bounce();
      raw_in = 8'h00;
      repeat (6) @(negedge clk);
      event_ack = 1'b1;
      @(negedge clk);
      event_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (stable !== 8'h00 || event_valid !== 1'b0) begin
         failures++;
         $display("FAIL bounce_setup got stable=%h valid=%b want 00/0", stable, event_valid);
      end
      raw_in = 8'h04;
      repeat (3) @(negedge clk);
      raw_in = 8'h00;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (stable !== 8'h00 || event_valid !== 1'b0) begin
            failures++;
            $display("FAIL bounce_reject cyc=%0d got stable=%h valid=%b want 00/0", c, stable, event_valid);
         end
      end
      raw_in = 8'h04;
      for (int e = 1; e <= 6; e++) begin
         @(negedge clk);
         checks++;
         if (stable !== (e == 6 ? 8'h04 : 8'h00)) begin
            failures++;
            $display("FAIL bounce_accept edge=%0d got stable=%h want %h", e, stable, (e == 6 ? 8'h04 : 8'h00));
         end
      end
      checks++;
      if (change_mask !== (CAP ? 8'h04 : 8'h00)) begin
         failures++;
         $display("FAIL bounce_mask got %h want %h", change_mask, (CAP ? 8'h04 : 8'h00));
      end
   endtask
   task automatic test_ack();
      for (int a = 0; a < 2; a++) begin
         event_ack = 1'b1;
         @(negedge clk);
         event_ack = 1'b0;
         @(negedge clk);
         checks++;
         if (change_mask !== 8'h00 || event_valid !== 1'b0 || stable !== 8'h04) begin
            failures++;
            $display("FAIL ack_%0d got mask=%h valid=%b stable=%h want 00/0/04", a, change_mask, event_valid, stable);
         end
      end
   endtask
   task automatic test_ack_flip();
      raw_in = 8'h05;
      repeat (6) @(negedge clk);
      raw_in = 8'h25;
      repeat (5) @(negedge clk);
      checks++;
      if (change_mask !== (CAP ? 8'h01 : 8'h00) || stable !== 8'h05) begin
         failures++;
         $display("FAIL ackflip_pre got mask=%h stable=%h want %h/05", change_mask, stable, (CAP ? 8'h01 : 8'h00));
      end
      event_ack = 1'b1;
      @(negedge clk);
      event_ack = 1'b0;
      checks++;
      if (change_mask !== (CAP ? 8'h20 : 8'h00) || event_valid !== CAP || stable !== 8'h25) begin
         failures++;
         $display("FAIL ackflip got mask=%h valid=%b stable=%h want %h/%b/25", change_mask, event_valid, stable, (CAP ? 8'h20 : 8'h00), CAP);
      end
   endtask
   task automatic test_midcount_reset();
      raw_in = 8'h80;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (stable !== 8'h00 || change_mask !== 8'h00 || event_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset got stable=%h mask=%h valid=%b want 00/00/0", stable, change_mask, event_valid);
      end
      reset = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         @(negedge clk);
         checks++;
         if (stable !== (e == 6 ? 8'h80 : 8'h00)) begin
            failures++;
            $display("FAIL midreset_relatch edge=%0d got stable=%h want %h", e, stable, (e == 6 ? 8'h80 : 8'h00));
         end
      end
   endtask
   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0) raw_in = raw_in ^ (8'h01 << $urandom_range(0, 7));
         event_ack = ($urandom_range(0, 5) == 0);
         @(negedge clk);
         checks++;
         if (stable !== m_stable || change_mask !== (CAP ? m_mask : 8'h00) || event_valid !== (CAP && m_mask != 0)) begin
            failures++;
            $display("FAIL random cyc=%0d got stable=%h mask=%h valid=%b want %h/%h/%b", c, stable, change_mask, event_valid,
                     m_stable, (CAP ? m_mask : 8'h00), (CAP && m_mask != 0));
         end
      end
      event_ack = 1'b0;
   endtask
   initial begin
      test_reset();
      test_bounce();
      test_ack();
      test_ack_flip();
      test_midcount_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pio_input_debounce.md
# pio_input_debounce

Synchronizing, debouncing front end for the slide switches and push-buttons that feed the Nios system's input PIOs (mode, BCD input, speed control). It sits between the board pins and the PIO `export` inputs. It delivers glitch-free stable levels and an optional latched change mask with a valid/ack handshake, so software sees each debounced transition exactly once.

## Interface
Parameters:
- `WIDTH`, 8: number of input bits.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz). Legal range is 1 to 2^24-1.
- `RESET_VALUE`, 0 (WIDTH bits): value of `stable` during and after reset.

Ports:
- `clk`  in  1: single clock, 50 MHz from CLOCK_50.
- `reset`  in  1: synchronous, active-high reset.
- `raw_in`  in  WIDTH: asynchronous pin levels.
- `stable`  out  WIDTH: debounced level, driven to the PIO export.
- `change_mask`  out  WIDTH: sticky per-bit "has toggled since last ack".
- `event_valid`  out  1: equals OR of `change_mask`.
- `event_ack`  in  1: single-cycle pulse that clears the captured changes.

## Operation
- All state updates on the rising edge of `clk`. Reset is synchronous and active-high; it has priority over all other activity.
- Synchronizer: two flops per bit, `raw_in` -> `s1` -> `s2`. Reset value is `RESET_VALUE`.
- Per-bit debounce counter:
  - Counter width is `clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2[i] == stable[i]`: the counter clears to 0.
  - Else, if the counter equals `DEBOUNCE_CYCLES-1`: `stable[i]` takes `s2[i]` and the counter clears.
  - Else: the counter increments.
  - Any bounce back to the old level restarts the count from 0. The counter never wraps.
- Flip vector: `flip[i]` is 1 in the cycle `stable[i]` is updated.
- Change capture, when compiled in:
  - Without ack: `change_mask <= change_mask | flip`.
  - When `event_ack == 1`: `change_mask <= flip`. A flip in the ack cycle is kept, not lost.
  - A repeated flip of an already-set bit leaves the bit set; multiple toggles merge into one.
  - `event_ack` while `event_valid == 0` has no effect.
- Reset values: `s1`, `s2` and `stable` = `RESET_VALUE`; counters = 0; `change_mask` = 0; `event_valid` = 0.
- Reset mid-count aborts the count. No flip is recorded for the reset itself.

## Timing
- Raw change settles before edge 0.
- `s1` captures it at edge 0 and `s2` at edge 1.
- The counter first increments at edge 2. `stable` updates at edge `DEBOUNCE_CYCLES+1`.
- Total latency from raw change to `stable` is `DEBOUNCE_CYCLES+2` edges, provided `raw_in` holds.
- With `DEBOUNCE_CYCLES = 1`, `stable` follows `s2` one cycle later (3 edges total).
- `change_mask` and `event_valid` assert on the same edge `stable` changes; their latency from `stable` is 0.
- `event_ack` takes effect on the edge where it is sampled high. `event_valid` deasserts the next cycle unless a flip coincides with the ack.
- All outputs are registered; there are no combinational paths from input to output.
- Bits are fully independent. Simultaneous flips on several bits all land in one `change_mask` update.

## Configuration
- Macro: `PIO_INPUT_DEBOUNCE_CHANGE_CAPTURE_EN`.
- Defined: the change-capture register, `change_mask`, `event_valid` and the `event_ack` handling are built.
- Undefined:
  - `change_mask` is tied to 0 and `event_valid` to 0.
  - `event_ack` is ignored.
  - Only the synchronizer, counters and `stable` remain. Port list unchanged.

## Test plan
Bench parameters: `WIDTH=8`, `DEBOUNCE_CYCLES=4`, `RESET_VALUE=8'h00`; macro defined unless noted.
1. Reset check: hold `reset` for 3 cycles with `raw_in=8'hFF` -> `stable=8'h00`, `change_mask=0`, `event_valid=0` throughout. After release, `stable=8'hFF` exactly 6 edges later and `change_mask=8'hFF`.
2. Bounce rejection: `raw_in[2]` toggles 0->1->0 with a 3-cycle high pulse -> `stable` stays 8'h00 and `event_valid` stays 0. Then hold `raw_in[2]=1` -> `stable=8'h04` 6 edges after the final rise.
3. Ack handshake: with `change_mask=8'h04`, pulse `event_ack` for one cycle -> `change_mask=0` and `event_valid=0` next cycle. A second ack does nothing.
4. Simultaneous ack and flip: time `raw_in[5]` rising so `stable[5]` flips on the same edge as `event_ack` while `change_mask=8'h01` -> `change_mask=8'h20` and `event_valid` stays 1.
5. Mid-count reset: hold `raw_in=8'h80`, assert `reset` 2 cycles before `stable` would update -> `stable=8'h00`. After release, the full 6-edge latency applies again.
6. Macro undefined: repeat test 1 -> `stable` behaves identically, while `change_mask=0` and `event_valid=0` at all times.
